square_mult_arbiter: RTL and testbench

- Shares one registered OP_W×OP_W squaring multiplier among NUM_REQ requesters, e.g. the x/y radius-squared paths and other spiral pixel-math units.
- Round-robin arbitration with a combinational grant.
- Two-stage pipeline (operand register, then product register).
- Tagged result stream with a valid/ready handshake and backpressure.
- Sits between the VGA-position normalisation logic and the radius LUT stage.

---
 rtl/square_mult_arbiter_if.sv | 25 ++
 rtl/square_mult_arbiter.sv | 91 +++++++++
 tb/tb_square_mult_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/square_mult_arbiter_if.sv
// Request/result bundle for the shared squaring multiplier.
// master: requesters plus result consumer. slave: the arbiter/multiplier.
interface square_mult_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned OP_W    = 7,
    parameter int unsigned TAG_W   = 2
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*OP_W-1:0] operand;
    logic [NUM_REQ-1:0]      gnt;
    logic                    res_valid;
    logic                    res_ready;
    logic [2*OP_W-1:0]       res_data;
    logic [TAG_W-1:0]        res_tag;

    modport master (
        output req, operand, res_ready,
        input  gnt, res_valid, res_data, res_tag
    );

    modport slave (
        input  req, operand, res_ready,
        output gnt, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/square_mult_arbiter.sv
// Round-robin shared squaring multiplier: combinational grant, operand register,
// product register, tagged valid/ready result stream with backpressure.
module square_mult_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned OP_W    = 7,
    parameter int unsigned TAG_W   = 2
) (
    input logic                  clk,
    input logic                  rst,
    square_mult_arbiter_if.slave bus
);
    localparam int unsigned ResW = 2 * OP_W;

    logic [TAG_W-1:0]   ptr_q;
    logic               s1_valid_q;
    logic [OP_W-1:0]    s1_op_q;
    logic [TAG_W-1:0]   s1_tag_q;
    logic               res_valid_q;
    logic [ResW-1:0]    res_data_q;
    logic [TAG_W-1:0]   res_tag_q;

    logic               adv;
    logic               any_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic [TAG_W-1:0]   sel_idx;
    logic [OP_W-1:0]    sel_op;
    logic [TAG_W-1:0]   ptr_d;

    // The whole pipeline moves only when the output slot is empty or being drained.
    assign adv = !res_valid_q || bus.res_ready;

    // Round-robin pick: first pass scans ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        any_gnt = 1'b0;
        gnt     = '0;
        sel_idx = '0;
        sel_op  = '0;
        ptr_d   = ptr_q;
        if (!rst && adv) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!any_gnt && bus.req[i] && (i >= int'(ptr_q))) begin
                    any_gnt = 1'b1;
                    gnt[i]  = 1'b1;
                    sel_idx = TAG_W'(i);
                    sel_op  = bus.operand[i*OP_W +: OP_W];
                end
            end
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!any_gnt && bus.req[i] && (i < int'(ptr_q))) begin
                    any_gnt = 1'b1;
                    gnt[i]  = 1'b1;
                    sel_idx = TAG_W'(i);
                    sel_op  = bus.operand[i*OP_W +: OP_W];
                end
            end
        end
        if (any_gnt) begin
            ptr_d = (sel_idx == TAG_W'(NUM_REQ - 1)) ? '0 : sel_idx + TAG_W'(1);
        end
    end

    // Pipeline stages and pointer; everything holds while the result is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_tag_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
        end else if (adv) begin
            s1_valid_q  <= any_gnt;
            res_valid_q <= s1_valid_q;
            ptr_q       <= ptr_d;
            if (any_gnt) begin
                s1_op_q  <= sel_op;
                s1_tag_q <= sel_idx;
            end
            if (s1_valid_q) begin
                res_data_q <= ResW'(s1_op_q) * ResW'(s1_op_q);
                res_tag_q  <= s1_tag_q;
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_tag   = res_tag_q;
endmodule

// File: tb/tb_square_mult_arbiter.sv
// Directed bench for square_mult_arbiter: stimulus pushes expected results on each
// expected grant; an independent monitor compares every presented result.
module tb_square_mult_arbiter;
    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned TAG_W   = 2;

    typedef struct {
        int tag;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cur_op[NUM_REQ];

    always #5 clk = ~clk;

    square_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .OP_W(OP_W), .TAG_W(TAG_W)) bus ();

    square_mult_arbiter #(.NUM_REQ(NUM_REQ), .OP_W(OP_W), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int a, input int b, input int c);
        cur_op[0] = a;
        cur_op[1] = b;
        cur_op[2] = c;
        bus.operand = {OP_W'(c), OP_W'(b), OP_W'(a)};
    endtask

    // Expect a grant to idx this cycle and queue the hand-computed square.
    task automatic grant_chk(input int idx, input int square);
        exp_t e;
        chk($sformatf("gnt to %0d", idx), 32'(bus.gnt), 1 << idx);
        e.tag  = idx;
        e.data = square;
        q.push_back(e);
    endtask

    task automatic chk_idle_gnt(input string name);
        chk(name, 32'(bus.gnt), 0);
    endtask

    task automatic drain();
        bus.req = '0;
        repeat (3) tick();
        chk("drained res_valid", 32'(bus.res_valid), 0);
    endtask

    task automatic do_reset();
        tick();
        rst     = 1'b1;
        bus.req = '0;
        tick();
        rst = 1'b0;
        q.delete();
    endtask

    // Monitor: every presented result must match the head of the queue; pop on transfer.
    always @(negedge clk) begin
        if (bus.res_valid === 1'b1) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected result: tag %0d data %0d, none expected (t=%0t)",
                         bus.res_tag, bus.res_data, $time);
            end else begin
                chk("res_tag", 32'(bus.res_tag), q[0].tag);
                chk("res_data", 32'(bus.res_data), q[0].data);
                if (bus.res_ready === 1'b1) void'(q.pop_front());
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.res_ready = 1'b1;
        set_ops(0, 0, 0);
        tick();
        tick();
        chk("reset gnt", 32'(bus.gnt), 0);
        chk("reset res_valid", 32'(bus.res_valid), 0);
        chk("reset res_data", 32'(bus.res_data), 0);
        chk("reset res_tag", 32'(bus.res_tag), 0);
        rst = 1'b0;

        // Single request: 5*5 = 25, two-cycle latency, one-cycle valid.
        tick();
        bus.req = 3'b001;
        set_ops(5, 0, 0);
        #1 grant_chk(0, 25);
        tick();
        bus.req = '0;
        #1 chk_idle_gnt("s1 gnt idle");
        chk("s1 res_valid cycle1", 32'(bus.res_valid), 0);
        tick();
        chk("s1 res_valid cycle2", 32'(bus.res_valid), 1);
        chk("s1 res_data cycle2", 32'(bus.res_data), 25);
        chk("s1 res_tag cycle2", 32'(bus.res_tag), 0);
        tick();
        chk("s1 res_valid cycle3", 32'(bus.res_valid), 0);

        // Continuous requests: fair order 0,1,2,0,1,2, one result per cycle.
        do_reset();
        set_ops(3, 10, 127);
        for (int k = 0; k < 6; k++) begin
            tick();
            bus.req = 3'b111;
            #1;
            case (k % 3)
                0:       grant_chk(0, 9);
                1:       grant_chk(1, 100);
                default: grant_chk(2, 16129);
            endcase
            if (k >= 2) chk("stream res_valid", 32'(bus.res_valid), 1);
        end
        tick();
        drain();

        // Pointer wrap: grant 1 leaves ptr=2, then 101 gives 2 before 0, ptr ends at 1.
        tick();
        bus.req = 3'b010;
        #1 grant_chk(1, 100);
        tick();
        bus.req = 3'b101;
        #1 grant_chk(2, 16129);
        tick();
        bus.req = 3'b001;
        #1 grant_chk(0, 9);
        tick();
        bus.req = 3'b111;
        #1 grant_chk(1, 100);
        tick();
        drain();

        // Backpressure: four stalled cycles with both stages full, then resume.
        do_reset();
        tick();
        bus.req = 3'b111;
        #1 grant_chk(0, 9);
        tick();
        #1 grant_chk(1, 100);
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.res_ready = 1'b0;
            #1 chk_idle_gnt("stall gnt");
            chk("stall res_valid", 32'(bus.res_valid), 1);
        end
        tick();
        bus.res_ready = 1'b1;
        #1 grant_chk(2, 16129);
        chk("resume res_valid", 32'(bus.res_valid), 1);
        tick();
        #1 grant_chk(0, 9);
        chk("resume no gap", 32'(bus.res_valid), 1);
        tick();
        bus.req = '0;
        #1 chk("resume third", 32'(bus.res_valid), 1);
        drain();

        // Reset while both stages hold data: contents dropped, pointer back to 0.
        do_reset();
        tick();
        bus.req = 3'b111;
        #1 grant_chk(0, 9);
        tick();
        #1 grant_chk(1, 100);
        tick();
        bus.res_ready = 1'b0;
        #1 chk_idle_gnt("pre-reset stall gnt");
        tick();
        rst           = 1'b1;
        bus.res_ready = 1'b1;
        #1 chk_idle_gnt("gnt during reset");
        tick();
        rst = 1'b0;
        q.delete();
        #1 chk("post-reset res_valid", 32'(bus.res_valid), 0);
        grant_chk(0, 9);
        tick();
        bus.req = 3'b010;
        #1 grant_chk(1, 100);
        tick();
        drain();

        // Withdrawal: req1 raised and dropped during a stall never yields a result.
        tick();
        bus.req = 3'b001;
        #1 grant_chk(0, 9);
        tick();
        bus.req = '0;
        tick();
        bus.res_ready = 1'b0;
        bus.req       = 3'b010;
        #1 chk_idle_gnt("withdraw stall gnt a");
        chk("withdraw stall res_valid", 32'(bus.res_valid), 1);
        tick();
        bus.req = '0;
        #1 chk_idle_gnt("withdraw stall gnt b");
        tick();
        bus.res_ready = 1'b1;
        #1 chk_idle_gnt("withdraw resume gnt");
        tick();
        drain();

        chk("scoreboard empty", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
